// File: rtl/datapath2.sv
// Downstream half of the single-cycle MIPS datapath: ALU, branch target, data memory, HI/LO multiplier.
// Define DATAPATH2_SIGNED_MUL_EN for two's-complement (MULT) multiplies; default is unsigned (MULTU).
module datapath2 #(
  parameter int unsigned DMEM_DEPTH = 64,
  parameter int unsigned DMEM_AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic [31:0] SrcA,
  input  logic [31:0] WriteData,
  input  logic        ALUSrc,
  input  logic [2:0]  ALUControl,
  input  logic        MemWrite,
  input  logic        MulStart,
  input  logic [1:0]  ResultSrc,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCTarget,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Stall
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t      state;
  logic [W-1:0]    sign_imm;
  logic [W-1:0]    src_b;
  logic [W-1:0]    alu_result;
  logic [W-1:0]    read_data;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_next;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            start_neg;
  logic [W-1:0]    mem [DMEM_DEPTH];
  logic [DMEM_AW-1:0] waddr;
  logic            unused_bits;

  assign sign_imm = {{16{Instr[15]}}, Instr[15:0]};
  assign PCPlus4  = PC + W'(4);
  assign PCTarget = PCPlus4 + {sign_imm[29:0], 2'b00};
  assign src_b    = ALUSrc ? sign_imm : WriteData;

  // ALU; undefined codes yield zero
  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'b010:  alu_result = SrcA + src_b;
      3'b110:  alu_result = SrcA - src_b;
      3'b000:  alu_result = SrcA & src_b;
      3'b001:  alu_result = SrcA | src_b;
      3'b111:  alu_result = W'($signed(SrcA) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  // Word addressed; byte offset ignored, upper bits alias
  assign waddr     = alu_result[DMEM_AW+1:2];
  assign read_data = mem[waddr];

  always_ff @(posedge clk) begin
    if (MemWrite && !Stall) mem[waddr] <= WriteData;
  end

  always_comb begin
    Result = alu_result;
    case (ResultSrc)
      2'b00: Result = alu_result;
      2'b01: Result = read_data;
      2'b10: Result = lo;
      2'b11: Result = hi;
      default: Result = alu_result;
    endcase
  end

  assign Stall = ((state == IDLE) && MulStart) || (state == BUSY);

`ifdef DATAPATH2_SIGNED_MUL_EN
  // Multiply magnitudes, fix the sign at the end; -2^31 maps to 0x80000000 unchanged
  assign a_mag     = SrcA[31]  ? W'(-SrcA)  : SrcA;
  assign b_mag     = src_b[31] ? W'(-src_b) : src_b;
  assign start_neg = SrcA[31] ^ src_b[31];
`else
  assign a_mag     = SrcA;
  assign b_mag     = src_b;
  assign start_neg = 1'b0;
`endif

  assign acc_next = acc + (mplier[0] ? mcand : PW'(0));

  // Iterative shift-add multiplier, one multiplier bit per BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MulStart) begin
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            neg    <= start_neg;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(31)) begin
            {hi, lo} <= neg ? PW'(-acc_next) : acc_next;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign unused_bits = ^{Instr[31:16], alu_result[W-1:DMEM_AW+2], alu_result[1:0]};

endmodule
